// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and write-back formatter (RV64).
//
// Captures memory-stage results on the rising edge of clk, extracts and
// extends load data from the naturally aligned doubleword returned by data
// memory, selects the write-back source and drives the register file write
// port one cycle later.  (regWrite, writeRegister, writeData) doubles as the
// forwarding source for earlier stages.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall, flush        hold stage / squash stage into a bubble (flush wins)
//   inValid             MEM slot holds a real instruction
//   inRegWrite          instruction writes rd
//   inMemToReg[1:0]     00 ALU, 01 load, 10 PC+4, 11 reserved (writes 0)
//   inFunct3[2:0]       load type (only meaningful for inMemToReg=01)
//   inRd                destination register
//   inAluResult         ALU result / load effective address
//   inMemData           aligned doubleword read from data memory
//   inPcPlus4           link value
//   regWrite            register file write enable
//   writeRegister       register file write address
//   writeData           register file write data
//   wbValid             stage holds a valid instruction
//   loadFault           captured load was misaligned or had funct3=111
//   retireCount[63:0]   retired-instruction counter (wraps)
//
// Handshake: there is no valid/ready back-pressure here.  A slot is taken on
// every rising edge unless stall holds it; inValid qualifies the slot and
// wbValid reports it, and flush or rst replace it with a bubble.
module mem_wb_stage #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              inValid,
  input  logic              inRegWrite,
  input  logic [1:0]        inMemToReg,
  input  logic [2:0]        inFunct3,
  input  logic [REG_AW-1:0] inRd,
  input  logic [XLEN-1:0]   inAluResult,
  input  logic [XLEN-1:0]   inMemData,
  input  logic [XLEN-1:0]   inPcPlus4,
  output logic              regWrite,
  output logic [REG_AW-1:0] writeRegister,
  output logic [XLEN-1:0]   writeData,
  output logic              wbValid,
  output logic              loadFault,
  output logic [63:0]       retireCount
);

  logic              reg_write_q,      reg_write_d;
  logic [REG_AW-1:0] write_register_q, write_register_d;
  logic [XLEN-1:0]   write_data_q,     write_data_d;
  logic              wb_valid_q,       wb_valid_d;
  logic              load_fault_q,     load_fault_d;
  logic [63:0]       retire_count_q,   retire_count_d;

  // Load formatting
  logic [2:0]      off;
  logic [XLEN-1:0] shifted;
  logic            fmt_fault;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wb_src;

  always_comb begin
    off     = inAluResult[2:0];
    // Move the addressed field down to bit 0 so every width extends from LSB.
    shifted = inMemData >> {off, 3'b000};

    fmt_fault = 1'b0;
    case (inFunct3)
      3'b000, 3'b100: fmt_fault = 1'b0;
      3'b001, 3'b101: fmt_fault = off[0];
      3'b010, 3'b110: fmt_fault = |off[1:0];
      3'b011:         fmt_fault = |off;
      default:        fmt_fault = 1'b1;  // funct3=111 is not a load
    endcase

    load_data = '0;
    case (inFunct3)
      3'b000:  load_data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      3'b011:  load_data = shifted;
      3'b100:  load_data = {{(XLEN-8){1'b0}},  shifted[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      3'b110:  load_data = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: load_data = '0;
    endcase
    if (fmt_fault) load_data = '0;

    wb_src = '0;
    case (inMemToReg)
      2'b00:   wb_src = inAluResult;
      2'b01:   wb_src = load_data;
      2'b10:   wb_src = inPcPlus4;
      default: wb_src = '0;
    endcase
  end

  // Next-state: reset > flush > stall > normal capture
  always_comb begin
    reg_write_d      = reg_write_q;
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    wb_valid_d       = wb_valid_q;
    load_fault_d     = load_fault_q;
    retire_count_d   = retire_count_q;

    if (rst) begin
      reg_write_d      = 1'b0;
      write_register_d = '0;
      write_data_d     = '0;
      wb_valid_d       = 1'b0;
      load_fault_d     = 1'b0;
      retire_count_d   = '0;
    end else if (flush) begin
      // Bubble; the retire count is architectural and survives a flush.
      reg_write_d      = 1'b0;
      write_register_d = '0;
      write_data_d     = '0;
      wb_valid_d       = 1'b0;
      load_fault_d     = 1'b0;
    end else if (!stall) begin
      load_fault_d     = inValid & (inMemToReg == 2'b01) & fmt_fault;
      wb_valid_d       = inValid;
      // x0 is never written, and a faulting load must not update rd.
      reg_write_d      = inValid & inRegWrite & (inRd != '0) & ~load_fault_d;
      write_register_d = inRd;
      write_data_d     = wb_src;
      if (inValid && !load_fault_d) retire_count_d = retire_count_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    reg_write_q      <= reg_write_d;
    write_register_q <= write_register_d;
    write_data_q     <= write_data_d;
    wb_valid_q       <= wb_valid_d;
    load_fault_q     <= load_fault_d;
    retire_count_q   <= retire_count_d;
  end

  assign regWrite      = reg_write_q;
  assign writeRegister = write_register_q;
  assign writeData     = write_data_q;
  assign wbValid       = wb_valid_q;
  assign loadFault     = load_fault_q;
  assign retireCount   = retire_count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: checks mem_wb_stage against a behavioural model of the
// write-back stage (byte-wise load extraction, priority rst/flush/stall).
module tb_mem_wb_stage;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush;
  logic        in_valid, in_reg_write;
  logic [1:0]  in_mem_to_reg;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [63:0] in_alu, in_mem, in_pc4;

  logic        reg_write, wb_valid, load_fault;
  logic [4:0]  write_register;
  logic [63:0] write_data, retire_count;

  mem_wb_stage #(.XLEN(64), .REG_AW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .inValid      (in_valid),
    .inRegWrite   (in_reg_write),
    .inMemToReg   (in_mem_to_reg),
    .inFunct3     (in_funct3),
    .inRd         (in_rd),
    .inAluResult  (in_alu),
    .inMemData    (in_mem),
    .inPcPlus4    (in_pc4),
    .regWrite     (reg_write),
    .writeRegister(write_register),
    .writeData    (write_data),
    .wbValid      (wb_valid),
    .loadFault    (load_fault),
    .retireCount  (retire_count)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic        m_rw, m_valid, m_fault;
  logic [4:0]  m_wr;
  logic [63:0] m_wd, m_cnt;

  // Load result built byte by byte from the addressed field.
  function automatic logic [63:0] load_model(input logic [63:0] data,
                                             input int f3, input int off,
                                             output logic fault);
    int size;
    logic [63:0] val;
    size  = 1 << (f3 % 4);
    fault = (f3 == 7) || (off % size != 0);
    val   = 64'd0;
    if (!fault) begin
      for (int i = 0; i < size; i++)
        val |= ((data >> (8 * (off + i))) & 64'hFF) << (8 * i);
      if (f3 < 4 && size < 8 && val[8*size-1])
        val |= ~((64'd1 << (8 * size)) - 64'd1);
    end
    return val;
  endfunction

  task automatic model_edge();
    logic        lf, flt;
    logic [63:0] ld, src;
    if (rst) begin
      m_rw = 0; m_wr = 0; m_wd = 0; m_valid = 0; m_fault = 0; m_cnt = 0;
    end else if (flush) begin
      m_rw = 0; m_wr = 0; m_wd = 0; m_valid = 0; m_fault = 0;
    end else if (!stall) begin
      ld  = load_model(in_mem, int'(in_funct3), int'(in_alu[2:0]), flt);
      src = (in_mem_to_reg == 2'd0) ? in_alu :
            (in_mem_to_reg == 2'd1) ? ld :
            (in_mem_to_reg == 2'd2) ? in_pc4 : 64'd0;
      lf      = in_valid && in_mem_to_reg == 2'd1 && flt;
      m_fault = lf;
      m_valid = in_valid;
      m_rw    = in_valid && in_reg_write && in_rd != 0 && !lf;
      m_wr    = in_rd;
      m_wd    = src;
      if (in_valid && !lf) m_cnt = m_cnt + 64'd1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic rw, input logic [1:0] mtr,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [63:0] alu, input logic [63:0] mem,
                       input logic [63:0] pc4);
    in_valid = v; in_reg_write = rw; in_mem_to_reg = mtr; in_funct3 = f3;
    in_rd = rd; in_alu = alu; in_mem = mem; in_pc4 = pc4;
  endtask

  task automatic ctrl(input logic r, input logic s, input logic f);
    rst = r; stall = s; flush = f;
  endtask

  // One rising edge, then compare every output on the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_val({tag, ".regWrite"},      64'(reg_write),      64'(m_rw));
    check_val({tag, ".writeRegister"}, 64'(write_register), 64'(m_wr));
    check_val({tag, ".writeData"},     write_data,          m_wd);
    check_val({tag, ".wbValid"},       64'(wb_valid),       64'(m_valid));
    check_val({tag, ".loadFault"},     64'(load_fault),     64'(m_fault));
    check_val({tag, ".retireCount"},   retire_count,        m_cnt);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- stimulus ----------------
  localparam logic [63:0] MEMPAT = 64'h6655_4433_2211_F0E0;

  initial begin
    m_rw = 0; m_wr = 0; m_wd = 0; m_valid = 0; m_fault = 0; m_cnt = 0;
    ctrl(1, 0, 0);
    drive(0, 0, 2'd0, 3'd0, 5'd0, 64'd0, 64'd0, 64'd0);

    // Reset for two cycles, then a plain ALU write
    step("reset0");
    step("reset1");
    check_val("reset_writeData", write_data, 64'd0);
    ctrl(0, 0, 0);
    drive(1, 1, 2'd0, 3'd0, 5'd5, 64'h1234, rnd64(), rnd64());
    step("alu_wr");
    check_val("alu_wr_data", write_data, 64'h1234);
    check_val("alu_wr_cnt", retire_count, 64'd1);

    // Every funct3 at every offset
    for (int f3 = 0; f3 < 8; f3++) begin
      for (int off = 0; off < 8; off++) begin
        drive(1, 1, 2'd1, 3'(f3), 5'd3, {rnd64() & ~64'h7} | 64'(off),
              MEMPAT, rnd64());
        step("load");
        if (f3 == 0 && off == 0)
          check_val("lb_off0", write_data, 64'hFFFF_FFFF_FFFF_FFE0);
        if (f3 == 4 && off == 1)
          check_val("lbu_off1", write_data, 64'hF0);
      end
    end

    // Misaligned lh
    drive(1, 1, 2'd1, 3'd1, 5'd9, 64'h1003, MEMPAT, 64'd0);
    step("lh_misalign");
    check_val("lh_misalign_fault", 64'(load_fault), 64'd1);

    // rd=0 never writes; PC+4 source
    drive(1, 1, 2'd0, 3'd0, 5'd0, 64'hDEAD, 64'd0, 64'd0);
    step("rd0");
    check_val("rd0_regWrite", 64'(reg_write), 64'd0);
    drive(1, 1, 2'd2, 3'd0, 5'd1, 64'hBEEF, 64'd0, 64'h104);
    step("pc4");
    check_val("pc4_data", write_data, 64'h104);

    // Stall holding rd=7 for three cycles while inputs change
    drive(1, 1, 2'd0, 3'd0, 5'd7, 64'h7777, 64'd0, 64'd0);
    step("pre_stall");
    ctrl(0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2'd0, 3'd0, 5'(i + 10), rnd64(), rnd64(), rnd64());
      step("stall");
    end
    // Stall and flush together give a bubble
    ctrl(0, 1, 1);
    step("stall_flush");
    // Reset while stalled clears everything
    ctrl(0, 0, 0);
    drive(1, 1, 2'd0, 3'd0, 5'd4, 64'h44, 64'd0, 64'd0);
    step("pre_rst");
    ctrl(1, 1, 0);
    step("rst_stalled");
    check_val("rst_stalled_cnt", retire_count, 64'd0);

    // Counter wrap from all ones
    ctrl(0, 0, 0);
    force dut.retire_count_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retire_count_q;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    drive(1, 0, 2'd0, 3'd0, 5'd0, 64'd1, 64'd0, 64'd0);
    step("wrap");
    check_val("wrap_cnt", retire_count, 64'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      ctrl($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 9) == 0);
      drive($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
            rnd64(), rnd64(), rnd64());
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
